// File: rtl/prio_vector_queue.sv
// Queues priority-encoder codes on each new request or code change.
// Show-ahead circular FIFO with a sticky overflow flag.
module prio_vector_queue #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    code_in,
  input  logic          req_any,
  output logic [2:0]    vec_out,
  output logic          vec_valid,
  input  logic          vec_ready,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          ovf_clr
);

  logic          r_req_d;
  logic [2:0]    r_code_d;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [2:0]    r_mem [DEPTH];

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_wr_en;
  logic w_drop;

  // A held request is captured once; a code change under a held request is captured again.
  assign w_push  = req_any & (~r_req_d | (code_in != r_code_d));
  assign w_pop   = vec_valid & vec_ready;
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  assign vec_out   = r_mem[r_rd_ptr];
  assign vec_valid = (r_count != '0);
  assign count     = r_count;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_d    <= 1'b0;
      r_code_d   <= 3'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_req_d  <= req_any;
      r_code_d <= code_in;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_en && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_wr_en && w_pop) r_count <= r_count - CW'(1);
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  // Storage is cleared so the head reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 3'd0;
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= code_in;
    end
  end

endmodule

// File: tb/tb_prio_vector_queue.sv
// Directed bench for prio_vector_queue: queue-based reference model checked
// every cycle, plus literal expectations at the key scenario points.
module tb_prio_vector_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    code_in;
  logic          req_any;
  logic [2:0]    vec_out;
  logic          vec_valid;
  logic          vec_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ovf_clr;

  int n_chk = 0;
  int n_err = 0;

  prio_vector_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_in   (code_in),
    .req_any   (req_any),
    .vec_out   (vec_out),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of codes plus the previous-cycle request view.
  int   m_q[$];
  logic m_req_d;
  logic [2:0] m_code_d;
  logic m_ovf;
  bit   m_pop, m_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_req_d  = 1'b0;
      m_code_d = 3'd0;
      m_ovf    = 1'b0;
    end else begin
      m_pop  = (m_q.size() != 0) && vec_ready;
      m_push = req_any && (!m_req_d || (code_in != m_code_d));
      if (m_pop) void'(m_q.pop_front());
      if (m_push && m_q.size() < DEPTH) m_q.push_back(int'(code_in));
      else if (m_push)                  m_ovf = 1'b1;
      else if (ovf_clr)                 m_ovf = 1'b0;
      if (m_push && m_q.size() == DEPTH && !m_pop && ovf_clr) m_ovf = 1'b1;
      m_req_d  = req_any;
      m_code_d = code_in;
    end
  end

  always @(negedge clk) begin
    chk("m_count", 32'(count), 32'(m_q.size()));
    chk("m_valid", 32'(vec_valid), 32'(m_q.size() != 0));
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    if (m_q.size() != 0) chk("m_head", 32'(vec_out), 32'(m_q[0]));
    if (!rst_n)          chk("m_rst_out", 32'(vec_out), 32'd0);
  end

  task automatic cyc(input logic r, input logic [2:0] c, input logic rd, input logic clr);
    req_any   = r;
    code_in   = c;
    vec_ready = rd;
    ovf_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic fill4();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 3'(i), 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_any = 1'b0; code_in = 3'd0; vec_ready = 1'b0; ovf_clr = 1'b0;
    #3;
    chk("rst_valid", 32'(vec_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out", 32'(vec_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single capture of a held request
    repeat (10) cyc(1'b1, 3'd5, 1'b0, 1'b0);
    chk("single_count", 32'(count), 32'd1);
    chk("single_head", 32'(vec_out), 32'd5);
    chk("single_valid", 32'(vec_valid), 32'd1);
    cyc(1'b0, 3'd5, 1'b0, 1'b0);
    cyc(1'b0, 3'd5, 1'b1, 1'b0);
    cyc(1'b0, 3'd5, 1'b1, 1'b0);
    chk("empty_pop_count", 32'(count), 32'd0);

    // Priority preempt
    repeat (3) cyc(1'b1, 3'd2, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 3'd7, 1'b0, 1'b0);
    chk("pre_count", 32'(count), 32'd2);
    chk("pre_head0", 32'(vec_out), 32'd2);
    cyc(1'b1, 3'd7, 1'b1, 1'b0);
    chk("pre_head1", 32'(vec_out), 32'd7);
    cyc(1'b1, 3'd7, 1'b1, 1'b0);
    chk("pre_empty", 32'(count), 32'd0);
    chk("pre_valid", 32'(vec_valid), 32'd0);
    cyc(1'b0, 3'd0, 1'b0, 1'b0);

    // Overflow drops the fifth code
    fill4();
    cyc(1'b1, 3'd6, 1'b0, 1'b0);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(vec_out), 32'd1);
    repeat (4) cyc(1'b0, 3'd0, 1'b1, 1'b0);
    chk("ovf_drained", 32'(count), 32'd0);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full with simultaneous push of line h and pop
    fill4();
    cyc(1'b1, 3'd0, 1'b1, 1'b0);
    chk("fsim_count", 32'(count), 32'd4);
    chk("fsim_ovf", 32'(overflow), 32'd0);
    chk("fsim_head", 32'(vec_out), 32'd2);
    repeat (3) cyc(1'b0, 3'd0, 1'b1, 1'b0);
    chk("fsim_last", 32'(vec_out), 32'd0);
    chk("fsim_last_cnt", 32'(count), 32'd1);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);

    // Drop and clear in the same cycle
    fill4();
    cyc(1'b1, 3'd5, 1'b0, 1'b1);
    chk("race_set", 32'(overflow), 32'd1);
    cyc(1'b1, 3'd5, 1'b0, 1'b1);
    chk("race_clr", 32'(overflow), 32'd0);
    repeat (4) cyc(1'b0, 3'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle, request held through release
    cyc(1'b1, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 3'd3, 1'b0, 1'b0);
    chk("ar_count3", 32'(count), 32'd3);
    code_in = 3'd6;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(vec_valid), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) cyc(1'b1, 3'd6, 1'b0, 1'b0);
    chk("ar_once", 32'(count), 32'd1);
    chk("ar_head", 32'(vec_out), 32'd6);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/prio_vector_queue.md
PRIO_VECTOR_QUEUE -- requirements
Module: prio_vector_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; SHALL be a power of 2, at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 code_in  input  3  registered 3-bit code from the upstream 8-line priority encoder; line a=7 (highest) down to line h=0.
REQ-005 req_any  input  1  OR of the 8 request lines (a..h); qualifies code_in, which reads 0 both for line h and for no request.
REQ-006 vec_out  output  3  code at the FIFO head.
REQ-007 vec_valid  output  1  high when vec_out holds a queued code.
REQ-008 vec_ready  input  1  consumer accepts vec_out on any edge where vec_valid and vec_ready are both high.
REQ-009 count  output  log2(DEPTH)+1  number of queued codes, 0..DEPTH.
REQ-010 overflow  output  1  sticky flag: a capture was dropped.
REQ-011 ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-012 Inputs SHALL be treated as synchronous to clk; the block SHALL NOT resynchronise them.
REQ-013 Registers SHALL hold req_d (req_any delayed one cycle) and code_d (code_in delayed one cycle).
REQ-014 Capture: push = req_any AND (NOT req_d OR code_in != code_d).
- A new request SHALL be captured.
- A code change while requests stay asserted (e.g. a higher-priority line arriving) SHALL be captured.
- A steady held request SHALL be captured exactly once.
REQ-015 Pop SHALL be vec_valid AND vec_ready.
REQ-016 Storage SHALL be a circular buffer with wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-017 A push SHALL write code_in at wr_ptr.
REQ-018 A pop SHALL advance rd_ptr.
REQ-019 Latency: a code pushed at edge N SHALL be on vec_out with vec_valid=1 from edge N onward, when the queue was empty.
REQ-020 vec_out SHALL be mem[rd_ptr] (show-ahead).
REQ-021 vec_valid SHALL equal (count != 0).
REQ-022 Empty, pop requested: vec_valid=0, so no pop occurs, and count SHALL NOT underflow.
REQ-023 Empty, push and vec_ready in the same cycle: the push SHALL occur; the pop SHALL NOT occur in that cycle.
REQ-024 Full, push without pop: code_in SHALL be dropped, wr_ptr and count SHALL be unchanged, and overflow SHALL be set at that edge.
REQ-025 Full, push and pop in the same cycle: both SHALL occur, count SHALL stay at DEPTH, and overflow SHALL NOT be set.
REQ-026 Non-full, push and pop in the same cycle: count SHALL be unchanged and both pointers SHALL advance.
REQ-027 ovf_clr=1 SHALL clear overflow at the next edge.
REQ-028 If a drop occurs in the same cycle as ovf_clr=1, set SHALL win and overflow stays 1.
REQ-029 When vec_valid=1 and vec_ready=0, vec_out SHALL remain stable.

Reset
REQ-030 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, clear:
- wr_ptr, rd_ptr, count
- req_d, code_d
- overflow
REQ-031 During and after reset: vec_valid=0, count=0, vec_out=0, overflow=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued codes.
REQ-033 The first edge after reset release SHALL treat req_any=1 as a new request (req_d=0).

Verification
REQ-034 Single capture: reset, then req_any=1, code_in=5 held 10 cycles, vec_ready=0 -> count=1, vec_out=5, vec_valid=1 throughout, no further pushes.
REQ-035 Priority preempt: code_in=2 with req_any=1 for 3 cycles, then code_in=7 -> two entries, 2 then 7; vec_ready=1 pops 2 then 7; then count=0 and vec_valid=0.
REQ-036 Overflow: DEPTH=4, vec_ready=0, push codes 1,2,3,4,6 -> count=4, overflow=1, head=1; pop all -> 1,2,3,4 in order; code 6 lost.
REQ-037 Full simultaneous: queue full, vec_ready=1, push 0 with req_any=1 (line h) -> count stays 4, overflow=0, the 0 later pops last.
REQ-038 Clear race: drop and ovf_clr=1 in the same cycle -> overflow=1; ovf_clr=1 alone next cycle -> overflow=0.
REQ-039 Async reset: rst_n low between clock edges with count=3 -> vec_valid=0 and count=0 before the next edge; req_any=1 held through release -> exactly one capture.
